// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with round-robin arbitration and a
// single registered output stage. One beat per cycle; drain and reload happen in the same cycle.
//
// Optional feature (macro STREAM_MUX_LAST_LOCK_EN): packet lock. A transfer without in_last
// freezes arbitration on that channel until a transfer carrying in_last completes the packet.
// This adds the in_last_i / out_last_o ports.
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   in_data_i    - channel i data at [i*WIDTH +: WIDTH]
//   in_valid_i   - per-channel valid
//   in_ready_o   - per-channel ready (one-hot or zero)
//   in_last_i    - per-channel end-of-packet (lock build only)
//   out_data_o   - registered output data
//   out_valid_o  - registered output valid
//   out_ready_i  - consumer ready
//   out_ch_o     - source channel of the current output beat
//   out_last_o   - registered end-of-packet (lock build only)
module stream_mux_rr #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned ChW  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data_i,
  input  logic [N_CH-1:0]       in_valid_i,
  output logic [N_CH-1:0]       in_ready_o,
`ifdef STREAM_MUX_LAST_LOCK_EN
  input  logic [N_CH-1:0]       in_last_i,
  output logic                  out_last_o,
`endif
  output logic [WIDTH-1:0]      out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ChW-1:0]        out_ch_o
);

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [ChW-1:0]   out_ch_q;
  logic [ChW-1:0]   rr_ptr_q;     // last granted channel

  logic             load;
  logic             any_req;
  logic [ChW-1:0]   grant;
  logic [ChW:0]     cand;
  logic [WIDTH-1:0] sel_data;

`ifdef STREAM_MUX_LAST_LOCK_EN
  logic out_last_q;
  logic lock_q;
`endif

  // Output register is empty or being drained this cycle.
  assign load = ~out_valid_q | out_ready_i;

  // Round-robin search starting one past the last grant, wrapping at N_CH-1.
  always_comb begin
    grant   = rr_ptr_q;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 1; k <= int'(N_CH); k++) begin
      cand = {1'b0, rr_ptr_q} + (ChW+1)'(k);
      if (cand >= (ChW+1)'(N_CH)) begin
        cand = cand - (ChW+1)'(N_CH);
      end
      if (!any_req && in_valid_i[cand[ChW-1:0]]) begin
        grant   = cand[ChW-1:0];
        any_req = 1'b1;
      end
    end
`ifdef STREAM_MUX_LAST_LOCK_EN
    // Mid-packet: only the locked channel may transfer.
    if (lock_q) begin
      grant   = rr_ptr_q;
      any_req = in_valid_i[rr_ptr_q];
    end
`endif
  end

  always_comb begin
    in_ready_o = '0;
    // rst_n gating keeps ready low while reset is held even though load is then high.
    if (rst_n && load && any_req) begin
      in_ready_o[grant] = 1'b1;
    end
  end

  assign sel_data = in_data_i[int'(grant)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      rr_ptr_q    <= ChW'(N_CH - 1);
`ifdef STREAM_MUX_LAST_LOCK_EN
      out_last_q  <= 1'b0;
      lock_q      <= 1'b0;
`endif
    end else if (load) begin
      if (any_req) begin
        out_data_q  <= sel_data;
        out_valid_q <= 1'b1;
        out_ch_q    <= grant;
        rr_ptr_q    <= grant;
`ifdef STREAM_MUX_LAST_LOCK_EN
        out_last_q  <= in_last_i[grant];
        lock_q      <= ~in_last_i[grant];
`endif
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_ch_o    = out_ch_q;
`ifdef STREAM_MUX_LAST_LOCK_EN
  assign out_last_o  = out_last_q;
`endif

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel stream multiplexer with valid/ready handshaking, round-robin arbitration and one registered output stage. It generalises the team's combinational select muxes: the block arbitrates among requesting channels itself and applies backpressure, so select lines are no longer driven externally. It merges several producer streams onto one consumer port, with one beat per cycle of throughput.

## Interface
- N_CH, default 4: number of input channels; legal range is 2 to 16.
- WIDTH, default 8: data width per channel in bits.
- clk, input, 1: clock; every register updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_data, input, N_CH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid, input, N_CH: per-channel valid.
- in_ready, output, N_CH: per-channel ready; a beat transfers when in_valid[i] and in_ready[i] are both high.
- out_data, output, WIDTH: registered output data.
- out_valid, output, 1: registered output valid.
- out_ready, input, 1: consumer ready.
- out_ch, output, $clog2(N_CH): source channel index of the current out_data beat.
- in_last, input, N_CH (only with STREAM_MUX_LAST_LOCK_EN): per-channel end-of-packet marker.
- out_last, output, 1 (only with STREAM_MUX_LAST_LOCK_EN): registered end-of-packet marker.

## Operation
- load = !out_valid | out_ready, meaning the output register is empty or is draining this cycle.
- Arbiter: rr_ptr holds the index of the last granted channel. The search starts at rr_ptr+1 and wraps from N_CH-1 to 0. The first channel with in_valid set is granted.
- in_ready[i] = load & (i == grant) & (some channel is requesting). At most one in_ready bit is high at a time.
- On a transfer:
  - out_data <= the granted channel's data.
  - out_ch <= grant.
  - out_valid <= 1.
  - rr_ptr <= grant.
- When load is high and no channel is requesting, out_valid <= 0. out_data and out_ch keep their values.
- When out_valid = 1 and out_ready = 0:
  - out_data, out_ch and rr_ptr are held.
  - All in_ready bits are 0.
- The arbiter ignores in_data and uses in_valid only. in_valid may deassert without a transfer having occurred.
- Reset values:
  - out_valid = 0, out_data = 0, out_ch = 0.
  - rr_ptr = N_CH-1, so channel 0 has first priority after reset.
  - out_last = 0 and lock = 0.
  - in_ready = 0 while rst_n is low.

## Timing
- Latency: a beat accepted in cycle n appears on out_data/out_valid in cycle n+1.
- Throughput: 1 beat per cycle while out_ready is held at 1.
- in_ready has a combinational dependency on out_ready and in_valid. in_data and in_valid must not depend combinationally on in_ready.
- Simultaneous drain and load in the same cycle is required behaviour. The output register reloads with no bubble.
- Single requester: the same channel is granted every cycle; the round-robin sequence does not skip it.
- Reset asserted mid-stream: outputs go to their reset values immediately, without waiting for a clock edge. Any in-flight beat is discarded.

## Configuration
- STREAM_MUX_LAST_LOCK_EN defined:
  - The in_last and out_last ports exist.
  - A lock flag sets on a transfer with in_last[grant] = 0 and clears on a transfer with in_last[grant] = 1.
  - While lock = 1, arbitration is frozen on rr_ptr: only that channel can receive in_ready, even if other channels are requesting.
  - out_last is registered together with out_data.
- STREAM_MUX_LAST_LOCK_EN undefined:
  - No in_last or out_last ports and no lock register.
  - Arbitration runs on every beat.

## Test plan
- Reset: hold rst_n = 0 with in_valid = 4'b1111 -> out_valid = 0, out_data = 0, out_ch = 0, in_ready = 4'b0000. After release, the first grant goes to channel 0.
- Single channel: in_valid = 4'b0100, channel 2 data = 8'hA5, out_ready = 1 -> one cycle later out_valid = 1, out_data = 8'hA5, out_ch = 2.
- Fairness: in_valid = 4'b1111 continuously with out_ready = 1 -> out_ch sequence is 0,1,2,3,0,1 with no idle cycles. With in_valid = 4'b1010 the sequence is 1,3,1,3.
- Backpressure: out_valid = 1 with out_ch = 1 and out_ready = 0 for 3 cycles -> out_data is stable and in_ready = 0. After out_ready returns to 1, the next beat comes from channel 2.
- Lock (macro defined): channel 1 sends 3 beats with in_last only on the third, while channels 0 and 2 are also valid -> out_ch sequence is 1,1,1,2, and out_last = 1 only on the third beat.
- Mid-stream reset: drop rst_n while out_valid = 1 and lock = 1 -> out_valid falls to 0 immediately without a clock edge. After release, with all channels valid, the first out_ch = 0.
